ladybird_bus_arbiter_rr: RTL and testbench

LADYBIRD_BUS_ARBITER_RR -- requirements
Module: ladybird_bus_arbiter_rr

---
 rtl/ladybird_bus_arbiter_rr.sv | 144 ++++++++++++++
 tb/tb_ladybird_bus_arbiter_rr.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_bus_arbiter_rr.sv
// N-to-1 bus arbiter with in-order response routing through a small index FIFO.
// Define LADYBIRD_BUS_ARBITER_RR_EN for round-robin arbitration; the default is fixed priority with index 0 highest.

module ladybird_bus_arbiter_rr_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 1
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] head,
  input  logic             gnt_fire,
  input  logic             rsp_fire,
  output logic             gnt,
  output logic             data_gnt
);
  assign gnt      = gnt_fire && (sel  == SEL_W'(IDX));
  assign data_gnt = rsp_fire && (head == SEL_W'(IDX));
endmodule

module ladybird_bus_arbiter_rr #(
  parameter int N_INPUT         = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  anrst,
  input  logic [N_INPUT-1:0]                    in_req,
  input  logic [N_INPUT*DATA_W/8-1:0]           in_wstrb,
  input  logic [N_INPUT*ADDR_W-1:0]             in_addr,
  input  logic [N_INPUT*DATA_W-1:0]             in_wdata,
  output logic [N_INPUT-1:0]                    in_gnt,
  output logic [N_INPUT-1:0]                    in_data_gnt,
  output logic [DATA_W-1:0]                     in_rdata,
  output logic                                  out_req,
  output logic [DATA_W/8-1:0]                   out_wstrb,
  output logic [ADDR_W-1:0]                     out_addr,
  output logic [DATA_W-1:0]                     out_wdata,
  input  logic                                  out_gnt,
  input  logic                                  out_data_gnt,
  input  logic [DATA_W-1:0]                     out_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
  output logic                                  err
);
  localparam int SEL_W  = $clog2(N_INPUT);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int STRB_W = DATA_W/8;

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] head;
  logic             any_req;
  logic             full, empty;
  logic             push, pop, stray;
  logic [SEL_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wptr, rptr;

`ifdef LADYBIRD_BUS_ARBITER_RR_EN
  logic [SEL_W-1:0] ptr;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst)    ptr <= '0;
    else if (push) ptr <= (sel == SEL_W'(N_INPUT-1)) ? '0 : sel + 1'b1;
  end
`endif

  // First asserted request at or after the search origin wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int i = 0; i < N_INPUT; i++) begin
`ifdef LADYBIRD_BUS_ARBITER_RR_EN
      idx = (int'(ptr) + i) % N_INPUT;
`else
      idx = i;
`endif
      if (!any_req && in_req[idx]) begin
        any_req = 1'b1;
        sel     = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    out_wstrb = '0;
    out_addr  = '0;
    out_wdata = '0;
    if (any_req) begin
      out_wstrb = in_wstrb[int'(sel)*STRB_W +: STRB_W];
      out_addr  = in_addr [int'(sel)*ADDR_W +: ADDR_W];
      out_wdata = in_wdata[int'(sel)*DATA_W +: DATA_W];
    end
  end

  assign full    = (outstanding == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (outstanding == '0);
  // Reset gates the strobes so nothing leaks out while anrst is held low.
  assign out_req = anrst & any_req & ~full;
  assign push    = out_req & out_gnt;
  assign pop     = anrst & out_data_gnt & ~empty;
  assign stray   = out_data_gnt & empty;
  assign head    = fifo[rptr];
  assign in_rdata = out_rdata;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= sel;
        wptr       <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (stray) err <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_INPUT; g++) begin : g_lane
    ladybird_bus_arbiter_rr_lane #(.IDX(g), .SEL_W(SEL_W)) u_lane (
      .sel      (sel),
      .head     (head),
      .gnt_fire (push),
      .rsp_fire (pop),
      .gnt      (in_gnt[g]),
      .data_gnt (in_data_gnt[g])
    );
  end
endmodule

// File: tb/tb_ladybird_bus_arbiter_rr.sv
// Bench for ladybird_bus_arbiter_rr: directed literal cases plus randomized traffic against a queue model.
module tb_ladybird_bus_arbiter_rr;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int SW = DW/8;

  logic            clk = 1'b0;
  logic            anrst;
  logic [N-1:0]    in_req;
  logic [N*SW-1:0] in_wstrb;
  logic [N*AW-1:0] in_addr;
  logic [N*DW-1:0] in_wdata;
  logic [N-1:0]    in_gnt, in_data_gnt;
  logic [DW-1:0]   in_rdata;
  logic            out_req;
  logic [SW-1:0]   out_wstrb;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_wdata;
  logic            out_gnt, out_data_gnt;
  logic [DW-1:0]   out_rdata;
  logic [2:0]      outstanding;
  logic            err;

  ladybird_bus_arbiter_rr #(.N_INPUT(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .anrst(anrst), .in_req(in_req), .in_wstrb(in_wstrb), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_gnt(in_gnt), .in_data_gnt(in_data_gnt), .in_rdata(in_rdata),
    .out_req(out_req), .out_wstrb(out_wstrb), .out_addr(out_addr), .out_wdata(out_wdata),
    .out_gnt(out_gnt), .out_data_gnt(out_data_gnt), .out_rdata(out_rdata),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of accepted requester ids, sticky error, round-robin origin.
  int q[$];
  bit m_err;
  int m_ptr;
  bit nxt_push, nxt_pop, nxt_stray;
  int nxt_sel;

  always begin : model
    int s;
    bit any, exp_req;
    logic [N-1:0] eg, ed;
    @(negedge clk);
    if (!anrst) begin
      q.delete();
      m_err = 0; m_ptr = 0;
      nxt_push = 0; nxt_pop = 0; nxt_stray = 0; nxt_sel = 0;
      check("rst out_req", out_req, 0);
      check("rst in_gnt", in_gnt, 0);
      check("rst in_data_gnt", in_data_gnt, 0);
      check("rst outstanding", outstanding, 0);
      check("rst err", err, 0);
    end else begin
      s = 0; any = 0;
      for (int i = 0; i < N; i++) begin
        int k;
`ifdef LADYBIRD_BUS_ARBITER_RR_EN
        k = (m_ptr + i) % N;
`else
        k = i;
`endif
        if (!any && in_req[k]) begin any = 1; s = k; end
      end
      exp_req = any && (q.size() < MO);
      eg = (exp_req && out_gnt) ? N'(1 << s) : '0;
      ed = (out_data_gnt && q.size() > 0) ? N'(1 << q[0]) : '0;
      check("out_req", out_req, exp_req);
      check("out_wstrb", out_wstrb, any ? in_wstrb[s*SW +: SW] : '0);
      check("out_addr", out_addr, any ? in_addr[s*AW +: AW] : '0);
      check("out_wdata", out_wdata, any ? in_wdata[s*DW +: DW] : '0);
      check("in_gnt", in_gnt, eg);
      check("in_data_gnt", in_data_gnt, ed);
      check("in_rdata", in_rdata, out_rdata);
      check("outstanding", outstanding, q.size());
      check("err", err, m_err);
      nxt_push  = exp_req && out_gnt;
      nxt_sel   = s;
      nxt_pop   = out_data_gnt && q.size() > 0;
      nxt_stray = out_data_gnt && q.size() == 0;
    end
    @(posedge clk);
    if (anrst) begin
      if (nxt_pop) void'(q.pop_front());
      if (nxt_push) begin
        q.push_back(nxt_sel);
        m_ptr = (nxt_sel + 1) % N;
      end
      if (nxt_stray) m_err = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_req = '0; in_wstrb = '0; in_addr = '0; in_wdata = '0;
    out_gnt = 0; out_data_gnt = 0; out_rdata = '0;
  endtask

  task automatic do_reset();
    anrst = 0;
    repeat (2) step();
    anrst = 1;
  endtask

  int src[3] = '{2, 0, 1};
  logic [DW-1:0] rd[3] = '{32'hA, 32'hB, 32'hC};

  initial begin
    idle();
    anrst = 0;
    step();
    do_reset();

    // Saturating requests; one response per cycle after the first keeps the FIFO from filling.
    in_req = 4'hF; out_gnt = 1;
    for (int c = 0; c < 8; c++) begin
      out_data_gnt = (c > 0);
      #1;
`ifdef LADYBIRD_BUS_ARBITER_RR_EN
      check("t1 rr order", in_gnt, 4'(1 << (c % 4)));
`else
      check("t2 fixed prio", in_gnt, 4'b0001);
`endif
      step();
    end

    // Fill to MAX_OUTSTANDING, then one response frees a slot.
    idle(); do_reset();
    in_req = 4'b0001; out_gnt = 1;
    for (int c = 0; c < 4; c++) begin
      #1; check("t3 fill gnt", in_gnt, 4'b0001);
      step();
    end
    #1;
    check("t3 full out_req", out_req, 0);
    check("t3 full gnt", in_gnt, 0);
    check("t3 full count", outstanding, 4);
    out_data_gnt = 1;
    #1; check("t3 pop dgnt", in_data_gnt, 4'b0001);
    step();
    out_data_gnt = 0;
    #1;
    check("t3 after pop count", outstanding, 3);
    check("t3 next gnt", in_gnt, 4'b0001);
    step();

    // Responses follow acceptance order 2,0,1.
    idle(); do_reset();
    out_gnt = 1;
    for (int i = 0; i < 3; i++) begin
      in_req = 4'(1 << src[i]);
      #1; check("t4 accept", in_gnt, 4'(1 << src[i]));
      step();
    end
    in_req = '0; out_gnt = 0; out_data_gnt = 1;
    for (int i = 0; i < 3; i++) begin
      out_rdata = rd[i];
      #1;
      check("t4 route", in_data_gnt, 4'(1 << src[i]));
      check("t4 rdata", in_rdata, rd[i]);
      step();
    end
    out_data_gnt = 0;
    #1; check("t4 drained", outstanding, 0);

    // Response with nothing in flight.
    idle(); do_reset();
    out_data_gnt = 1;
    #1; check("t5 no dgnt", in_data_gnt, 0);
    step();
    out_data_gnt = 0;
    #1; check("t5 err set", err, 1);

    // Reset with three in flight (err still set from above).
    in_req = 4'b1000; out_gnt = 1;
    repeat (3) step();
    out_gnt = 0;
    #1; check("t6 pre count", outstanding, 3);
    anrst = 0;
    #1;
    check("t6 count clr", outstanding, 0);
    check("t6 err clr", err, 0);
    check("t6 gnt clr", in_gnt, 0);
    out_gnt = 1; out_data_gnt = 1;
    repeat (2) step();
    check("t6 err held", err, 0);
    idle(); anrst = 1;
    step();
    out_data_gnt = 1;
    step();
    out_data_gnt = 0;
    #1; check("t6 stale rsp err", err, 1);
    do_reset();

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      in_req = N'($urandom_range(0, 15));
      in_wstrb = N*SW'($urandom());
      for (int l = 0; l < N; l++) begin
        in_addr[l*AW +: AW]  = AW'($urandom());
        in_wdata[l*DW +: DW] = $urandom();
      end
      out_gnt = ($urandom_range(0, 3) != 0);
      out_data_gnt = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
      out_rdata = $urandom();
      if ($urandom_range(0, 499) == 0) anrst = 0;
      step();
      anrst = 1;
    end

    idle();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
